cic_comb_scheduler: RTL

Time-multiplexed comb section and decimation controller for the CIC decimator. It counts integrator-rate samples and captures every R-th one. It then runs all N comb stages through one shared subtractor over N consecutive clocks, keeping each stage's differential-delay history locally. It sits between the integrator chain and the CIC output, replacing a chain of N separate comb blocks.

---
 rtl/cic_comb_scheduler.sv | 114 +++++++++++
 1 files changed

// File: rtl/cic_comb_scheduler.sv
// Time-multiplexed CIC comb chain with decimation control: every R-th input sample
// is pushed through N comb stages via one shared subtractor, one stage per clock.
module cic_comb_scheduler #(
    parameter int N         = 4,
    parameter int M         = 1,
    parameter int R         = 8,
    parameter int DataWidth = 18
) (
    input  logic                 Clk_i,
    input  logic                 Rst_i,
    input  logic                 Clear_i,
    input  logic [DataWidth-1:0] Data_i,
    input  logic                 DataNd_i,
    output logic [DataWidth-1:0] Data_o,
    output logic                 DataValid_o,
    output logic                 Busy_o,
    output logic                 Overrun_o
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                              state_q, state_d;
    logic [SW-1:0]                       stg_q, stg_d;
    logic [CW-1:0]                       dec_q, dec_d;
    logic [DataWidth-1:0]                acc_q, acc_d;
    logic [DataWidth-1:0]                data_q, data_d;
    logic [N-1:0][M-1:0][DataWidth-1:0]  hist_q, hist_d;
    logic                                valid_q, valid_d;
    logic                                ovr_q, ovr_d;
    logic                                capture;
    logic [DataWidth-1:0]                diff;

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        dec_d   = dec_q;
        acc_d   = acc_q;
        data_d  = data_q;
        hist_d  = hist_q;
        valid_d = 1'b0;
        ovr_d   = 1'b0;
        capture = DataNd_i && (dec_q == CW'(R - 1));
        // Plain modulo-2^DataWidth subtract; the CIC relies on the wrap.
        diff    = acc_q - hist_q[stg_q][M-1];

        if (Clear_i) begin
            state_d = IDLE;
            stg_d   = '0;
            dec_d   = '0;
            acc_d   = '0;
            hist_d  = '0;
        end else begin
            if (DataNd_i)
                dec_d = capture ? '0 : dec_q + CW'(1);
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        acc_d   = Data_i;
                        stg_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // Only the active stage's delay line shifts; it takes the stage input.
                    for (int k = 1; k < M; k++)
                        hist_d[stg_q][k] = hist_q[stg_q][k-1];
                    hist_d[stg_q][0] = acc_q;
                    acc_d = diff;
                    ovr_d = capture;
                    if (stg_q == SW'(N - 1)) begin
                        data_d  = diff;
                        valid_d = 1'b1;
                        stg_d   = '0;
                        state_d = IDLE;
                    end else begin
                        stg_d = stg_q + SW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state_q <= IDLE;
            stg_q   <= '0;
            dec_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            hist_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            dec_q   <= dec_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            hist_q  <= hist_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Data_o      = data_q;
    assign DataValid_o = valid_q;
    assign Busy_o      = (state_q == RUN);
    assign Overrun_o   = ovr_q;

endmodule
